// File: rtl/fifo_ctrl_hs_pkg.sv
// Shared definitions for the handshake FIFO controller.
// Contents: default widths and flag thresholds, the controller FSM state
// encoding, and the per-cycle action the FSM takes when it is idle.
package fifo_ctrl_hs_pkg;

  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 4;
  localparam int DEF_AF_LEVEL = 12;
  localparam int DEF_AE_LEVEL = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_RD_WAIT = 2'd2
  } fsm_state_e;

  // What the FSM does with the pending slots on the current edge.
  typedef enum logic [2:0] {
    ACT_NONE      = 3'd0,
    ACT_ISSUE_WR  = 3'd1,
    ACT_ISSUE_RD  = 3'd2,
    ACT_REJECT_WR = 3'd3,
    ACT_REJECT_RD = 3'd4
  } fsm_act_e;

endpackage

// File: rtl/fifo_ctrl_hs_if.sv
// Request/acknowledge port towards the SDRAM-backed FIFO store.
//   we/re  : level requests from the controller, held until ack
//   addr   : entry address (write or read pointer)
//   wdata  : data of the outstanding write
//   rdata  : read data, valid in the cycle ack=1 during a read
//   ack    : 1-cycle completion from the memory side
// Modports: master = controller, slave = memory.
interface fifo_ctrl_hs_if
  import fifo_ctrl_hs_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output we, re, addr, wdata, input rdata, ack);
  modport slave  (input we, re, addr, wdata, output rdata, ack);
endinterface

// File: rtl/fifo_ctrl_hs_req_slot.sv
// One-entry pending-request register.
//   req/data_i : incoming 1-cycle request and its payload
//   free       : the FSM consumed (issued or rejected) the entry this cycle
//   flush      : synchronous empty
//   pending    : an entry is held
//   data_o     : payload of the held entry
//   drop       : request arrived while the entry is held and not being freed
// A request landing in the same cycle as free refills the slot.
module fifo_ctrl_hs_req_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         req,
  input  logic [W-1:0] data_i,
  input  logic         free,
  output logic         pending,
  output logic [W-1:0] data_o,
  output logic         drop
);

  assign drop = req && pending && !free;

  // NOTE: state is written with <= so every flop samples pre-edge values;
  // the payload is reset too, it is a single register, not a RAM array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      data_o  <= '0;
    end else if (flush) begin
      pending <= 1'b0;
    end else if (req && (!pending || free)) begin
      pending <= 1'b1;
      data_o  <= data_i;
    end else if (free) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_ctrl_hs.sv
// FIFO controller in front of a variable-latency request/ack memory.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               sync flush (deferred to the ack of an outstanding access)
//   wr_req, wr_data     1-cycle write request with data
//   rd_req              1-cycle read request
//   rd_data, rd_valid   last read word (held) and its 1-cycle update strobe
//   count               committed entries, 0..DEPTH
//   full, empty, almost_full, almost_empty   flags decoded from count
//   overflow, underflow, req_drop             sticky error flags
//   busy                FSM active or a request pending
//   mem                 memory port (master side)
// Requests are buffered in one write and one read slot; the FSM serves
// them one at a time, evaluating full/empty when it issues, not on capture.
module fifo_ctrl_hs
  import fifo_ctrl_hs_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic              req_drop,
  output logic              busy,
  fifo_ctrl_hs_if.master    mem
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_AF    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  CNT_AE    = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  fsm_state_e state, state_nxt;
  fsm_act_e   act;

  logic              wr_pend, rd_pend, wr_drop, rd_drop, wr_free, rd_free;
  logic [DATA_W-1:0] wr_slot_data;
  logic              rd_slot_unused;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              clear_pend;
  logic              flush;

  // Flags follow the committed count only.
  assign full         = (count == CNT_DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_AF);
  assign almost_empty = (count <= CNT_AE);

  // In IDLE a clear applies at once; during an access it waits for the ack
  // so the memory never sees an abandoned cycle.
  assign flush = (state == ST_IDLE) ? clear : (mem.ack && (clear || clear_pend));

  assign wr_free = (act == ACT_ISSUE_WR) || (act == ACT_REJECT_WR);
  assign rd_free = (act == ACT_ISSUE_RD) || (act == ACT_REJECT_RD);

  fifo_ctrl_hs_req_slot #(.W(DATA_W)) u_wr_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .req     (wr_req),
    .data_i  (wr_data),
    .free    (wr_free),
    .pending (wr_pend),
    .data_o  (wr_slot_data),
    .drop    (wr_drop)
  );

  fifo_ctrl_hs_req_slot #(.W(1)) u_rd_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .req     (rd_req),
    .data_i  (1'b0),
    .free    (rd_free),
    .pending (rd_pend),
    .data_o  (rd_slot_unused),
    .drop    (rd_drop)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and slot action.
  // NOTE: both outputs get a default first so no path leaves them unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    act       = ACT_NONE;
    case (state)
      ST_IDLE: begin
        if (!clear) begin
          if (wr_pend && rd_pend)  act = full ? ACT_ISSUE_RD : ACT_ISSUE_WR;
          else if (wr_pend)        act = full ? ACT_REJECT_WR : ACT_ISSUE_WR;
          else if (rd_pend)        act = empty ? ACT_REJECT_RD : ACT_ISSUE_RD;
        end
        if (act == ACT_ISSUE_WR)      state_nxt = ST_WR_WAIT;
        else if (act == ACT_ISSUE_RD) state_nxt = ST_RD_WAIT;
      end
      ST_WR_WAIT: if (mem.ack) state_nxt = ST_IDLE;
      ST_RD_WAIT: if (mem.ack) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: requests drop the moment the state (or reset) leaves WAIT.
  always_comb begin
    mem.we    = (state == ST_WR_WAIT);
    mem.re    = (state == ST_RD_WAIT);
    mem.addr  = mem_addr_q;
    mem.wdata = mem_wdata_q;
    busy      = (state != ST_IDLE) || wr_pend || rd_pend;
  end

  // Pointers, count, stickies and the read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      req_drop    <= 1'b0;
      clear_pend  <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (flush) begin
        // The completing access (if any) is not committed.
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        overflow   <= 1'b0;
        underflow  <= 1'b0;
        req_drop   <= 1'b0;
        clear_pend <= 1'b0;
      end else begin
        case (act)
          ACT_ISSUE_WR: begin
            mem_addr_q  <= wr_ptr;
            mem_wdata_q <= wr_slot_data;
          end
          ACT_ISSUE_RD:  mem_addr_q <= rd_ptr;
          ACT_REJECT_WR: overflow   <= 1'b1;
          ACT_REJECT_RD: underflow  <= 1'b1;
          default: ;
        endcase
        if (wr_drop || rd_drop) req_drop <= 1'b1;
        if (state != ST_IDLE && clear) clear_pend <= 1'b1;
        if (state == ST_WR_WAIT && mem.ack) begin
          wr_ptr <= wr_ptr + PTR_ONE;
          count  <= count + CNT_ONE;
        end
        if (state == ST_RD_WAIT && mem.ack) begin
          rd_ptr <= rd_ptr + PTR_ONE;
          count  <= count - CNT_ONE;
        end
      end
      // A completed read is always delivered, even when a flush discards it.
      if (state == ST_RD_WAIT && mem.ack) begin
        rd_data  <= mem.rdata;
        rd_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_hs.sv
// Self-checking bench for fifo_ctrl_hs (ADDR_W=2, DATA_W=4, AF=3, AE=1).
// A memory responder acks every request two cycles after it rises. A
// queue-based FIFO model tracks committed contents from observed memory
// completions and checks count, flags, addresses and read data each cycle;
// directed scenarios add literal expectations.
module tb_fifo_ctrl_hs;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int AF     = 3;
  localparam int AE     = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              wr_req = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_req = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   count;
  logic              full, empty, almost_full, almost_empty;
  logic              overflow, underflow, req_drop, busy;

  fifo_ctrl_hs_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  fifo_ctrl_hs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .wr_req       (wr_req),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .req_drop     (req_drop),
    .busy         (busy),
    .mem          (mem_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [DATA_W-1:0] mem_arr [DEPTH];
  int                ack_cnt = 0;

  initial begin
    mem_bus.ack   = 1'b0;
    mem_bus.rdata = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_bus.ack = 1'b0;
      ack_cnt     = 0;
    end else if (mem_bus.ack) begin
      mem_bus.ack = 1'b0;
      ack_cnt     = 0;
    end else if (mem_bus.we || mem_bus.re) begin
      ack_cnt++;
      if (ack_cnt == 2) begin
        mem_bus.ack = 1'b1;
        if (mem_bus.we) mem_arr[mem_bus.addr] = mem_bus.wdata;
        else            mem_bus.rdata = mem_arr[mem_bus.addr];
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // ---------------- model + per-cycle compare ----------------
  logic [DATA_W-1:0] stim_q[$];   // writes expected to reach memory, in order
  logic [DATA_W-1:0] fifo_q[$];   // committed contents
  logic [DATA_W-1:0] got_q[$];    // every rd_data delivered with rd_valid
  logic [ADDR_W-1:0] addr_log[$]; // address of every completed write
  bit                order_q[$];  // completion order: 0 = write, 1 = read
  int                m_wr, m_rd;
  bit                clr_pend;
  bit                exp_rv;
  logic [DATA_W-1:0] exp_rd;
  int                n_we_issue, n_re_issue;
  bit                prev_we, prev_re, seen7;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        stim_q.delete();
        fifo_q.delete();
        m_wr = 0; m_rd = 0; clr_pend = 0; exp_rv = 0; exp_rd = '0;
        prev_we = 0; prev_re = 0;
      end else begin
        // Outputs after the last edge against the model.
        check("count", 32'(count), 32'(fifo_q.size()));
        check("full", full, fifo_q.size() == DEPTH);
        check("empty", empty, fifo_q.size() == 0);
        check("almost_full", almost_full, fifo_q.size() >= AF);
        check("almost_empty", almost_empty, fifo_q.size() <= AE);
        check("rd_valid", rd_valid, exp_rv);
        if (exp_rv) check("rd_data", rd_data, exp_rd);
        if (rd_valid) got_q.push_back(rd_data);
        check("we_re_exclusive", mem_bus.we && mem_bus.re, 0);
        if (mem_bus.we && !prev_we) n_we_issue++;
        if (mem_bus.re && !prev_re) n_re_issue++;
        if (mem_bus.we && mem_bus.wdata == 4'h7) seen7 = 1;
        prev_we = mem_bus.we;
        prev_re = mem_bus.re;

        // Predict the effect of the coming edge.
        begin
          bit access, flush;
          logic [DATA_W-1:0] d;
          access = mem_bus.we || mem_bus.re;
          flush  = (!access && clear) || (access && mem_bus.ack && (clear || clr_pend));
          if (access && !mem_bus.ack && clear) clr_pend = 1;
          exp_rv = 0;
          if (mem_bus.ack && mem_bus.we) begin
            order_q.push_back(1'b0);
            addr_log.push_back(mem_bus.addr);
            check("write_expected", stim_q.size() > 0, 1);
            if (stim_q.size() > 0) begin
              d = stim_q.pop_front();
              check("mem_wdata", mem_bus.wdata, d);
              check("wr_addr", mem_bus.addr, m_wr);
              if (!flush) begin
                fifo_q.push_back(d);
                m_wr = (m_wr + 1) % DEPTH;
              end
            end
          end
          if (mem_bus.ack && mem_bus.re) begin
            order_q.push_back(1'b1);
            check("read_expected", fifo_q.size() > 0, 1);
            check("rd_addr", mem_bus.addr, m_rd);
            exp_rv = 1;
            if (fifo_q.size() > 0) exp_rd = fifo_q.pop_front();
            if (!flush) m_rd = (m_rd + 1) % DEPTH;
          end
          if (flush) begin
            fifo_q.delete();
            stim_q.delete();
            m_wr = 0; m_rd = 0; clr_pend = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; clear = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d, input bit commits);
    @(negedge clk);
    wr_req = 1'b1; wr_data = d;
    if (commits) stim_q.push_back(d);
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic rd();
    @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    @(negedge clk);
    while (busy && i < 60) begin
      @(negedge clk);
      i++;
    end
    check("idle_within_budget", busy, 0);
    @(negedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [DATA_W-1:0] exp3 [3];
    logic [DATA_W-1:0] exp6 [6];
    logic [ADDR_W-1:0] exp_addr [6];
    int base, n_we0, n_re0, ngot0;
    exp3     = '{4'hA, 4'h5, 4'hC};
    exp6     = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset state
    do_reset();
    @(negedge clk); #2;
    check("rst_count", 32'(count), 0);
    check("rst_empty", empty, 1);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    check("rst_req_drop", req_drop, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_we", mem_bus.we, 0);
    check("rst_rd_data", rd_data, 0);

    // Write A,5,C then read them back
    wr(4'hA, 1); wait_idle();
    wr(4'h5, 1); wait_idle();
    wr(4'hC, 1); wait_idle();
    check("t1_count", 32'(count), 3);
    check("t1_almost_full", almost_full, 1);
    base = got_q.size();
    for (int i = 0; i < 3; i++) begin rd(); wait_idle(); end
    check("t1_nreads", got_q.size() - base, 3);
    for (int i = 0; i < 3; i++)
      if (base + i < got_q.size()) check($sformatf("t1_rd%0d", i), got_q[base + i], exp3[i]);
    check("t1_empty", empty, 1);

    // Overflow: fill, then write 7
    for (int i = 1; i <= 4; i++) begin wr(4'(i), 1); wait_idle(); end
    check("t2_full", full, 1);
    n_we0 = n_we_issue;
    wr(4'h7, 0); wait_idle();
    check("t2_overflow", overflow, 1);
    check("t2_count", 32'(count), 4);
    check("t2_no_issue", n_we_issue - n_we0, 0);
    check("t2_no_wdata7", seen7, 0);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    @(negedge clk); #2;
    check("t2_clear_count", 32'(count), 0);
    check("t2_clear_overflow", overflow, 0);

    // Underflow after reset
    do_reset();
    n_re0 = n_re_issue; ngot0 = got_q.size();
    rd(); wait_idle();
    check("t3_underflow", underflow, 1);
    check("t3_no_mem_re", n_re_issue - n_re0, 0);
    check("t3_no_rd_valid", got_q.size() - ngot0, 0);

    // Six write/read pairs, pointers wrap
    do_reset();
    base = got_q.size();
    n_we0 = addr_log.size();
    for (int i = 0; i < 6; i++) begin
      wr(4'(i + 1), 1); wait_idle();
      rd(); wait_idle();
    end
    check("t4_nreads", got_q.size() - base, 6);
    check("t4_nwrites", addr_log.size() - n_we0, 6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < got_q.size()) check($sformatf("t4_rd%0d", i), got_q[base + i], exp6[i]);
      if (n_we0 + i < addr_log.size()) check($sformatf("t4_addr%0d", i), addr_log[n_we0 + i], exp_addr[i]);
    end
    check("t4_count", 32'(count), 0);

    // Full with simultaneous read and write
    do_reset();
    for (int i = 1; i <= 4; i++) begin wr(4'(i), 1); wait_idle(); end
    base = got_q.size(); n_we0 = order_q.size();
    @(negedge clk);
    wr_req = 1'b1; wr_data = 4'h9; rd_req = 1'b1;
    stim_q.push_back(4'h9);
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    wait_idle();
    check("t5_ncompl", order_q.size() - n_we0, 2);
    if (order_q.size() >= n_we0 + 2) begin
      check("t5_first_is_read", order_q[n_we0], 1);
      check("t5_then_write", order_q[n_we0 + 1], 0);
    end
    if (got_q.size() > base) check("t5_rd_data", got_q[base], 4'h1);
    check("t5_count", 32'(count), 4);
    check("t5_overflow", overflow, 0);

    // Clear during WR_WAIT
    do_reset();
    rd(); wait_idle();
    check("t6_underflow_set", underflow, 1);
    wr(4'hE, 1);
    for (int i = 0; i < 20 && !mem_bus.we; i++) @(negedge clk);
    check("t6_we_seen", mem_bus.we, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t6_we_held", mem_bus.we, 1);
    wait_idle();
    check("t6_count", 32'(count), 0);
    check("t6_underflow_clr", underflow, 0);
    check("t6_overflow", overflow, 0);
    check("t6_req_drop", req_drop, 0);
    base = got_q.size();
    wr(4'h3, 1); wait_idle();
    if (addr_log.size() > 0) check("t6_wptr_zero", addr_log[addr_log.size() - 1], 0);
    rd(); wait_idle();
    if (got_q.size() > base) check("t6_rd_data", got_q[base], 4'h3);

    // Request into an occupied write slot
    do_reset();
    @(negedge clk); wr_req = 1'b1; wr_data = 4'h1; stim_q.push_back(4'h1);
    @(negedge clk); wr_data = 4'h2; stim_q.push_back(4'h2);
    @(negedge clk); wr_data = 4'h3;
    @(negedge clk); wr_req = 1'b0;
    wait_idle();
    check("t7_req_drop", req_drop, 1);
    check("t7_count", 32'(count), 2);
    check("t7_overflow", overflow, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
